// File: rtl/vga_pkg.sv
// Shared display-timing types and constants for the 600p video path.
package vga_pkg;

    typedef struct packed {
        int res;
        int fp;
        int sync;
        int bp;
    } timing_t;

    localparam timing_t H_600P = '{res: 800, fp: 40, sync: 128, bp: 88};
    localparam timing_t V_600P = '{res: 600, fp: 1,  sync: 4,   bp: 23};

    localparam int SX_W = 11;
    localparam int SY_W = 10;

    typedef logic [SX_W-1:0] sx_t;
    typedef logic [SY_W-1:0] sy_t;

    function automatic int h_total(timing_t t);
        return t.res + t.fp + t.sync + t.bp;
    endfunction

    function automatic int v_total(timing_t t);
        return t.res + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_600p.sv
// 800x600@60 timing generator in the clk_pix domain: cascaded x/y counters
// with every output decoded from the next-state coordinates and registered.
module vga_timing_600p
    import vga_pkg::*;
#(
    parameter int   H_RES  = H_600P.res,
    parameter int   H_FP   = H_600P.fp,
    parameter int   H_SYNC = H_600P.sync,
    parameter int   H_BP   = H_600P.bp,
    parameter int   V_RES  = V_600P.res,
    parameter int   V_FP   = V_600P.fp,
    parameter int   V_SYNC = V_600P.sync,
    parameter int   V_BP   = V_600P.bp,
    parameter logic H_POL  = 1'b1,
    parameter logic V_POL  = 1'b1
) (
    input  logic clk_pix,
    input  logic rst,
    input  logic clk_pix_locked,
    output sx_t  sx,
    output sy_t  sy,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic line,
    output logic frame
);

    localparam timing_t H_T = '{res: H_RES, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_T = '{res: V_RES, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int H_TOTAL = h_total(H_T);
    localparam int V_TOTAL = v_total(V_T);

    generate
        if (H_TOTAL > (1 << SX_W) || V_TOTAL > (1 << SY_W)) begin : g_width_check
            $error("vga_timing_600p: timing totals exceed sx/sy coordinate widths");
        end
    endgenerate

    localparam sx_t SX_LAST  = sx_t'(H_TOTAL - 1);
    localparam sy_t SY_LAST  = sy_t'(V_TOTAL - 1);
    localparam sx_t SX_VIS   = sx_t'(H_RES);
    localparam sy_t SY_VIS   = sy_t'(V_RES);
    localparam sx_t HS_START = sx_t'(H_RES + H_FP);
    localparam sx_t HS_STOP  = sx_t'(H_RES + H_FP + H_SYNC);
    localparam sy_t VS_START = sy_t'(V_RES + V_FP);
    localparam sy_t VS_STOP  = sy_t'(V_RES + V_FP + V_SYNC);

    logic idle;
    sx_t  sx_nxt;
    sy_t  sy_nxt;

    assign idle = rst || !clk_pix_locked;

    // Idle parks the counters on the last pixel, so the first active step
    // naturally lands on (0,0) and restarts a clean frame.
    always_comb begin
        sx_nxt = sx + 1'b1;
        sy_nxt = sy;
        if (sx == SX_LAST) begin
            sx_nxt = '0;
            sy_nxt = (sy == SY_LAST) ? '0 : sy + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (idle) begin
            sx    <= SX_LAST;
            sy    <= SY_LAST;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de    <= 1'b0;
            line  <= 1'b0;
            frame <= 1'b0;
        end else begin
            sx    <= sx_nxt;
            sy    <= sy_nxt;
            hsync <= (sx_nxt >= HS_START && sx_nxt < HS_STOP) ? H_POL : ~H_POL;
            vsync <= (sy_nxt >= VS_START && sy_nxt < VS_STOP) ? V_POL : ~V_POL;
            de    <= (sx_nxt < SX_VIS) && (sy_nxt < SY_VIS);
            line  <= (sx_nxt == '0);
            frame <= (sx_nxt == '0) && (sy_nxt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_600p.sv
// Bench for vga_timing_600p: a full 600p instance plus a short-frame instance
// (same horizontal timing, 11 lines) so whole frames fit in a short run.
module tb_vga_timing_600p;

    localparam int HR  = 800;
    localparam int HFP = 40;
    localparam int HSY = 128;
    localparam int HBP = 88;
    localparam int HT  = HR + HFP + HSY + HBP;

    localparam int VR_F = 600, VFP_F = 1, VSY_F = 4, VBP_F = 23;
    localparam int VT_F = VR_F + VFP_F + VSY_F + VBP_F;
    localparam int VR_S = 4,   VFP_S = 1, VSY_S = 4, VBP_S = 2;
    localparam int VT_S = VR_S + VFP_S + VSY_S + VBP_S;
    localparam int FT_S = HT * VT_S;

    typedef struct packed {
        logic [10:0] sx;
        logic [9:0]  sy;
        logic        hs;
        logic        vs;
        logic        de;
        logic        line;
        logic        frame;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock = 1'b1;

    logic [10:0] sx_f, sx_s;
    logic [9:0]  sy_f, sy_s;
    logic hs_f, vs_f, de_f, line_f, frame_f;
    logic hs_s, vs_s, de_s, line_s, frame_s;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    int  mt = -1;

    always #5 clk = ~clk;

    vga_timing_600p dut_full (
        .clk_pix(clk), .rst(rst), .clk_pix_locked(lock),
        .sx(sx_f), .sy(sy_f), .hsync(hs_f), .vsync(vs_f),
        .de(de_f), .line(line_f), .frame(frame_f)
    );

    vga_timing_600p #(.V_RES(VR_S), .V_FP(VFP_S), .V_SYNC(VSY_S), .V_BP(VBP_S)) dut_short (
        .clk_pix(clk), .rst(rst), .clk_pix_locked(lock),
        .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .line(line_s), .frame(frame_s)
    );

    // Reference: cycles elapsed since leaving idle, -1 while idle.
    always @(posedge clk) mt <= (rst || !lock) ? -1 : mt + 1;

    function automatic obs_t model(int t, int vr, int vfp, int vsy, int vt);
        obs_t o;
        int x, y;
        if (t < 0) begin
            o.sx = 11'(HT - 1);
            o.sy = 10'(vt - 1);
            o.hs = 1'b0; o.vs = 1'b0; o.de = 1'b0; o.line = 1'b0; o.frame = 1'b0;
            return o;
        end
        x = t % HT;
        y = (t / HT) % vt;
        o.sx    = 11'(x);
        o.sy    = 10'(y);
        o.hs    = (x >= HR + HFP) && (x < HR + HFP + HSY);
        o.vs    = (y >= vr + vfp) && (y < vr + vfp + vsy);
        o.de    = (x < HR) && (y < vr);
        o.line  = (x == 0);
        o.frame = (x == 0) && (y == 0);
        return o;
    endfunction

    always @(negedge clk) begin : monitor
        obs_t of, os, ef, es;
        if (chk_en) begin
            of = {sx_f, sy_f, hs_f, vs_f, de_f, line_f, frame_f};
            os = {sx_s, sy_s, hs_s, vs_s, de_s, line_s, frame_s};
            ef = model(mt, VR_F, VFP_F, VSY_F, VT_F);
            es = model(mt, VR_S, VFP_S, VSY_S, VT_S);
            n_checks++;
            if (of !== ef) begin
                n_fail++;
                $display("FAIL model_full t=%0d got sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b exp sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b",
                         mt, of.sx, of.sy, of.hs, of.vs, of.de, of.line, of.frame,
                         ef.sx, ef.sy, ef.hs, ef.vs, ef.de, ef.line, ef.frame);
            end
            n_checks++;
            if (os !== es) begin
                n_fail++;
                $display("FAIL model_short t=%0d got sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b exp sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b",
                         mt, os.sx, os.sy, os.hs, os.vs, os.de, os.line, os.frame,
                         es.sx, es.sy, es.hs, es.vs, es.de, es.line, es.frame);
            end
            n_checks++;
            if ((de_f && !(sx_f < 11'd800 && sy_f < 10'd600)) || (hs_f && de_f) ||
                sx_f > 11'd1055 || sy_f > 10'd627) begin
                n_fail++;
                $display("FAIL invariant_full got sx=%0d sy=%0d de=%b hs=%b required de->visible, !(hs&de), bounds",
                         sx_f, sy_f, de_f, hs_f);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        lock = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sx_f !== 11'd1055) begin n_fail++; $display("FAIL reset_sx got %0d exp 1055", sx_f); end
        n_checks++;
        if (sy_f !== 10'd627) begin n_fail++; $display("FAIL reset_sy got %0d exp 627", sy_f); end
        n_checks++;
        if ({hs_f, vs_f, de_f, line_f, frame_f} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_outs got %b exp 00000", {hs_f, vs_f, de_f, line_f, frame_f});
        end
        n_checks++;
        if (sy_s !== 10'(VT_S - 1)) begin n_fail++; $display("FAIL reset_sy_short got %0d exp %0d", sy_s, VT_S - 1); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sx_f, sy_f} !== 21'd0) begin n_fail++; $display("FAIL first_xy got %0d,%0d exp 0,0", sx_f, sy_f); end
        n_checks++;
        if ({de_f, line_f, frame_f} !== 3'b111) begin
            n_fail++; $display("FAIL first_strobes got de/line/frame=%b exp 111", {de_f, line_f, frame_f});
        end
    endtask

    task automatic test_line();
        int last_line, n_line, sp_min, sp_max;
        int de_from, de_to, hs_rise, hs_fall;
        logic p_de, p_hs;
        logic [10:0] p_sx;
        last_line = 0; n_line = 0; sp_min = 1 << 30; sp_max = -1;
        de_from = -1; de_to = -1; hs_rise = -1; hs_fall = -1;
        p_de = de_f; p_hs = hs_f; p_sx = sx_f;
        for (int i = 1; i <= 2 * HT + 4; i++) begin
            @(negedge clk);
            if (p_de && !de_f && de_from < 0) begin de_from = int'(p_sx); de_to = int'(sx_f); end
            if (!p_hs && hs_f && hs_rise < 0) hs_rise = int'(sx_f);
            if (p_hs && !hs_f && hs_fall < 0) hs_fall = int'(sx_f);
            if (line_f) begin
                n_line++;
                if (i - last_line < sp_min) sp_min = i - last_line;
                if (i - last_line > sp_max) sp_max = i - last_line;
                last_line = i;
            end
            p_de = de_f; p_hs = hs_f; p_sx = sx_f;
        end
        n_checks++;
        if (de_from != 799 || de_to != 800) begin
            n_fail++; $display("FAIL de_fall got %0d->%0d exp 799->800", de_from, de_to);
        end
        n_checks++;
        if (hs_rise != 840) begin n_fail++; $display("FAIL hsync_rise got sx=%0d exp 840", hs_rise); end
        n_checks++;
        if (hs_fall != 968) begin n_fail++; $display("FAIL hsync_fall got sx=%0d exp 968", hs_fall); end
        n_checks++;
        if (n_line != 2 || sp_min != HT || sp_max != HT) begin
            n_fail++; $display("FAIL line_spacing got n=%0d min=%0d max=%0d exp n=2 spacing %0d", n_line, sp_min, sp_max, HT);
        end
    endtask

    task automatic test_frame();
        int vs_cyc, vs_first, vs_last, de_cyc, de_bad, next_frame, last_sx, last_sy;
        vs_cyc = 0; vs_first = -1; vs_last = -1; de_cyc = 0; de_bad = 0;
        next_frame = -1; last_sx = -1; last_sy = -1;
        for (int i = 0; i < FT_S + 10 && frame_s !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (frame_s !== 1'b1) begin
            n_fail++; $display("FAIL frame_wait got no frame strobe exp one within %0d cycles", FT_S + 10);
            return;
        end
        for (int i = 1; i <= FT_S; i++) begin
            @(negedge clk);
            if (vs_s) begin
                vs_cyc++;
                if (vs_first < 0) vs_first = int'(sy_s);
                vs_last = int'(sy_s);
            end
            if (de_s) de_cyc++;
            if (de_s && int'(sy_s) >= VR_S) de_bad++;
            if (i == FT_S - 1) begin last_sx = int'(sx_s); last_sy = int'(sy_s); end
            if (frame_s && next_frame < 0) next_frame = i;
        end
        n_checks++;
        if (vs_cyc != VSY_S * HT || vs_first != VR_S + VFP_S || vs_last != VR_S + VFP_S + VSY_S - 1) begin
            n_fail++; $display("FAIL vsync_lines got cyc=%0d rows %0d..%0d exp cyc=%0d rows %0d..%0d",
                               vs_cyc, vs_first, vs_last, VSY_S * HT, VR_S + VFP_S, VR_S + VFP_S + VSY_S - 1);
        end
        n_checks++;
        if (de_bad != 0 || de_cyc != HR * VR_S) begin
            n_fail++; $display("FAIL de_frame got cyc=%0d blank_hits=%0d exp cyc=%0d blank_hits=0", de_cyc, de_bad, HR * VR_S);
        end
        n_checks++;
        if (last_sx != HT - 1 || last_sy != VT_S - 1) begin
            n_fail++; $display("FAIL frame_last got %0d,%0d exp %0d,%0d", last_sx, last_sy, HT - 1, VT_S - 1);
        end
        n_checks++;
        if (next_frame != FT_S || {sx_s, sy_s} !== 21'd0) begin
            n_fail++; $display("FAIL frame_period got %0d at %0d,%0d exp %0d at 0,0", next_frame, sx_s, sy_s, FT_S);
        end
    endtask

    task automatic test_lock_drop();
        int tx, ty, hold;
        for (int k = 0; k < 2; k++) begin
            tx   = (k == 0) ? 400 : int'($urandom_range(0, HT - 1));
            ty   = (k == 0) ? 2   : int'($urandom_range(0, VT_S - 1));
            hold = (k == 0) ? 3   : int'($urandom_range(1, 6));
            for (int i = 0; i < FT_S + 10 && !(int'(sx_s) == tx && int'(sy_s) == ty); i++) @(negedge clk);
            n_checks++;
            if (!(int'(sx_s) == tx && int'(sy_s) == ty)) begin
                n_fail++; $display("FAIL lock_wait got %0d,%0d exp %0d,%0d", sx_s, sy_s, tx, ty);
                return;
            end
            lock = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({sx_s, sy_s, hs_s, vs_s, de_s, line_s, frame_s} !== {11'd1055, 10'(VT_S - 1), 5'b00000}) begin
                n_fail++; $display("FAIL lock_idle_short got sx=%0d sy=%0d outs=%b exp 1055,%0d,00000",
                                   sx_s, sy_s, {hs_s, vs_s, de_s, line_s, frame_s}, VT_S - 1);
            end
            n_checks++;
            if ({sx_f, sy_f, de_f, frame_f} !== {11'd1055, 10'd627, 2'b00}) begin
                n_fail++; $display("FAIL lock_idle_full got sx=%0d sy=%0d de=%b frame=%b exp 1055,627,0,0", sx_f, sy_f, de_f, frame_f);
            end
            repeat (hold - 1) @(negedge clk);
            lock = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({sx_s, sy_s, frame_s, line_s, frame_f} !== {21'd0, 3'b111}) begin
                n_fail++; $display("FAIL relock_start got sx=%0d sy=%0d frame=%b line=%b frame_full=%b exp 0,0,1,1,1",
                                   sx_s, sy_s, frame_s, line_s, frame_f);
            end
        end
    endtask

    task automatic test_rst_vsync();
        for (int i = 0; i < FT_S + 10 && !(sx_s == 11'd900 && sy_s == 10'd6); i++) @(negedge clk);
        n_checks++;
        if ({hs_s, vs_s} !== 2'b11 || sx_s !== 11'd900) begin
            n_fail++; $display("FAIL vsync_pre got sx=%0d sy=%0d hs=%b vs=%b exp 900,6,1,1", sx_s, sy_s, hs_s, vs_s);
            return;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({hs_s, vs_s, sx_s, sy_s} !== {2'b00, 11'd1055, 10'(VT_S - 1)}) begin
            n_fail++; $display("FAIL rst_in_vsync got hs=%b vs=%b sx=%0d sy=%0d exp 0,0,1055,%0d", hs_s, vs_s, sx_s, sy_s, VT_S - 1);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sx_s, sy_s, frame_s} !== {21'd0, 1'b1}) begin
            n_fail++; $display("FAIL rst_restart got sx=%0d sy=%0d frame=%b exp 0,0,1", sx_s, sy_s, frame_s);
        end
        repeat ($urandom_range(5, 50)) @(negedge clk);
        rst = 1'b1;
        lock = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sx_f, sy_f, de_f, line_f, frame_f} !== {11'd1055, 10'd627, 3'b000}) begin
            n_fail++; $display("FAIL both_idle got sx=%0d sy=%0d de=%b line=%b frame=%b exp 1055,627,0,0,0",
                               sx_f, sy_f, de_f, line_f, frame_f);
        end
        rst = 1'b0;
        lock = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sx_f, sy_f, frame_f} !== {21'd0, 1'b1}) begin
            n_fail++; $display("FAIL both_restart got sx=%0d sy=%0d frame=%b exp 0,0,1", sx_f, sy_f, frame_f);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (mt == 0) begin
                n_checks++;
                if ({sx_f, sy_f, frame_f, sx_s, sy_s, frame_s} !== {21'd0, 1'b1, 21'd0, 1'b1}) begin
                    n_fail++; $display("FAIL random_restart got full %0d,%0d f=%b short %0d,%0d f=%b exp 0,0,1 both",
                                       sx_f, sy_f, frame_f, sx_s, sy_s, frame_s);
                end
            end
            r = int'($urandom_range(0, 299));
            rst  = (r < 2);
            lock = !(r >= 1 && r < 4);
        end
        rst = 1'b0;
        lock = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_lock_drop();
        test_rst_vsync();
        test_random();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion exp finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
